// File: rtl/tlc_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tlc_phase_scheduler
//
// Request scheduler placed in front of the adaptive traffic-light sequencer.
// It latches vehicle, pedestrian and emergency requests, picks one winner
// when idle, and hands that phase to the sequencer. The hand-off uses a
// valid/ready command followed by a done pulse. While a normal phase runs,
// a newly pending emergency raises a one-cycle preempt request.
//
// Arbitration order:
//   emergency (fixed N>S>E>W)  >  [starving vehicles, round-robin]  >
//   pedestrian  >  vehicles (round-robin from rr pointer)
//
// Optional feature macro: TLC_STARVE_GUARD_EN
//   Defined     : per-direction wait counters saturating at MAX_WAIT. A
//                 direction at MAX_WAIT ranks above pedestrian requests.
//   Not defined : no counters, plain arbitration order.
//
// Ports:
//   clk                clock, rising edge
//   reset              asynchronous active-low reset
//   car_n/s/e/w        vehicle presence (pulse or level)
//   pedestrian_button  walk request
//   emergency[3:0]     emergency request, bit3=N bit2=S bit1=E bit0=W
//   phase_valid        phase command valid
//   phase_ready        sequencer accepts the command
//   phase_sel[2:0]     0=N 1=S 2=E 3=W 4=PED
//   phase_time[TW-1:0] phase duration in cycles
//   phase_emerg        command is an emergency phase
//   phase_done         sequencer finished the phase (1-cycle pulse)
//   preempt            1-cycle request to terminate the current phase early
//   busy               a phase is issued or running
// -----------------------------------------------------------------------------
module tlc_phase_scheduler #(
    parameter int TW         = 8,
    parameter int GREEN_TIME = 20,
    parameter int WALK_TIME  = 15,
    parameter int EMERG_TIME = 30,
    parameter int MAX_WAIT   = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          car_n,
    input  logic          car_s,
    input  logic          car_e,
    input  logic          car_w,
    input  logic          pedestrian_button,
    input  logic [3:0]    emergency,
    output logic          phase_valid,
    input  logic          phase_ready,
    output logic [2:0]    phase_sel,
    output logic [TW-1:0] phase_time,
    output logic          phase_emerg,
    input  logic          phase_done,
    output logic          preempt,
    output logic          busy
);

    // Phase durations must be representable on phase_time.
    generate
        if ((GREEN_TIME >= (1 << TW)) || (WALK_TIME >= (1 << TW)) ||
            (EMERG_TIME >= (1 << TW)) || (MAX_WAIT < 1)) begin : g_param_err
            $error("tlc_phase_scheduler: phase time does not fit in TW bits or MAX_WAIT < 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [2:0] SEL_PED = 3'd4;

    // Round-robin search over a 4-bit mask starting at 'start'.
    // Returns {found, index}. Scanning from the farthest offset down lets the
    // nearest hit overwrite earlier ones.
    function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (mask[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Fixed-priority search, lowest index (N) first. Returns {found, index}.
    function automatic logic [2:0] fixed_pick(input logic [3:0] mask);
        logic [2:0] res;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            if (mask[k]) begin
                res = {1'b1, 2'(k)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Registers
    state_t        r_state;
    logic          r_phase_valid;
    logic [2:0]    r_phase_sel;
    logic [TW-1:0] r_phase_time;
    logic          r_phase_emerg;
    logic          r_preempt;
    logic          r_preempt_used;
    logic          r_busy;
    logic [3:0]    r_veh_pend;
    logic          r_ped_pend;
    logic [3:0]    r_emg_pend;     // direction order: [0]=N .. [3]=W
    logic [1:0]    r_rr;

    // Combinational signals
    state_t        w_state_nxt;
    logic          w_valid_nxt;
    logic [2:0]    w_sel_nxt;
    logic [TW-1:0] w_time_nxt;
    logic          w_emerg_nxt;
    logic          w_preempt_nxt;
    logic          w_preempt_used_nxt;
    logic          w_busy_nxt;
    logic [1:0]    w_rr_nxt;
    logic          w_handshake;
    logic [3:0]    w_car;
    logic [3:0]    w_emg_in;
    logic [3:0]    w_veh_clr;
    logic          w_ped_clr;
    logic [3:0]    w_emg_clr;
    logic [3:0]    w_starve_mask;
    logic [2:0]    w_emg_pick;
    logic [2:0]    w_starve_pick;
    logic [2:0]    w_veh_pick;
    logic          w_grant_valid;
    logic [2:0]    w_grant_sel;
    logic [TW-1:0] w_grant_time;
    logic          w_grant_emerg;

    assign w_car    = {car_w, car_e, car_s, car_n};
    // Emergency input is MSB=N; reorder so index matches phase_sel numbering.
    assign w_emg_in = {emergency[0], emergency[1], emergency[2], emergency[3]};

`ifdef TLC_STARVE_GUARD_EN
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] r_wait [4];

    // Per-direction wait counters: count while pending, saturate, clear on service
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < 4; d++) begin
                r_wait[d] <= '0;
            end
        end else begin
            for (int d = 0; d < 4; d++) begin
                if (w_veh_clr[d]) begin
                    r_wait[d] <= '0;
                end else if (r_veh_pend[d] && (r_wait[d] != CW'(MAX_WAIT))) begin
                    r_wait[d] <= r_wait[d] + CW'(1);
                end else begin
                    r_wait[d] <= r_wait[d];
                end
            end
        end
    end

    // Starving directions: counter saturated and request still pending
    always_comb begin
        w_starve_mask = 4'b0000;
        for (int d = 0; d < 4; d++) begin
            w_starve_mask[d] = r_veh_pend[d] && (r_wait[d] == CW'(MAX_WAIT));
        end
    end
`else
    assign w_starve_mask = 4'b0000;
`endif

    // Arbitration among the visible pending requests
    always_comb begin
        w_emg_pick    = fixed_pick(r_emg_pend);
        w_starve_pick = rr_pick(w_starve_mask, r_rr);
        w_veh_pick    = rr_pick(r_veh_pend, r_rr);
        w_grant_valid = 1'b0;
        w_grant_sel   = 3'd0;
        w_grant_time  = '0;
        w_grant_emerg = 1'b0;
        if (w_emg_pick[2]) begin
            w_grant_valid = 1'b1;
            w_grant_sel   = {1'b0, w_emg_pick[1:0]};
            w_grant_time  = TW'(EMERG_TIME);
            w_grant_emerg = 1'b1;
        end else if (w_starve_pick[2]) begin
            w_grant_valid = 1'b1;
            w_grant_sel   = {1'b0, w_starve_pick[1:0]};
            w_grant_time  = TW'(GREEN_TIME);
        end else if (r_ped_pend) begin
            w_grant_valid = 1'b1;
            w_grant_sel   = SEL_PED;
            w_grant_time  = TW'(WALK_TIME);
        end else if (w_veh_pick[2]) begin
            w_grant_valid = 1'b1;
            w_grant_sel   = {1'b0, w_veh_pick[1:0]};
            w_grant_time  = TW'(GREEN_TIME);
        end else begin
            w_grant_valid = 1'b0;
        end
    end

    // Next-state and next-output logic of the IDLE/ISSUE/RUN controller
    always_comb begin
        w_state_nxt        = r_state;
        w_valid_nxt        = r_phase_valid;
        w_sel_nxt          = r_phase_sel;
        w_time_nxt         = r_phase_time;
        w_emerg_nxt        = r_phase_emerg;
        w_busy_nxt         = r_busy;
        w_preempt_nxt      = 1'b0;
        w_preempt_used_nxt = r_preempt_used;
        w_rr_nxt           = r_rr;
        w_handshake        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_state_nxt        = ST_ISSUE;
                    w_valid_nxt        = 1'b1;
                    w_sel_nxt          = w_grant_sel;
                    w_time_nxt         = w_grant_time;
                    w_emerg_nxt        = w_grant_emerg;
                    w_busy_nxt         = 1'b1;
                    w_preempt_used_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // Command fields stay frozen until the sequencer accepts it.
                if (phase_ready) begin
                    w_handshake = 1'b1;
                    w_state_nxt = ST_RUN;
                    w_valid_nxt = 1'b0;
                    if (!r_phase_emerg && (r_phase_sel != SEL_PED)) begin
                        w_rr_nxt = r_phase_sel[1:0] + 2'd1;
                    end else begin
                        w_rr_nxt = r_rr;
                    end
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_RUN: begin
                // A done on the same edge as a newly visible emergency wins:
                // the emergency is then served by the next arbitration.
                if (phase_done) begin
                    w_state_nxt = ST_IDLE;
                    w_sel_nxt   = 3'd0;
                    w_time_nxt  = '0;
                    w_emerg_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                end else if (!r_phase_emerg && (|r_emg_pend) && !r_preempt_used) begin
                    w_preempt_nxt      = 1'b1;
                    w_preempt_used_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
                w_sel_nxt   = 3'd0;
                w_time_nxt  = '0;
                w_emerg_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Clear masks for the latch served by the accepted command
    always_comb begin
        w_veh_clr = 4'b0000;
        w_ped_clr = 1'b0;
        w_emg_clr = 4'b0000;
        if (w_handshake) begin
            if (r_phase_emerg) begin
                w_emg_clr[r_phase_sel[1:0]] = 1'b1;
            end else if (r_phase_sel == SEL_PED) begin
                w_ped_clr = 1'b1;
            end else begin
                w_veh_clr[r_phase_sel[1:0]] = 1'b1;
            end
        end else begin
            w_ped_clr = 1'b0;
        end
    end

    // Controller state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered command outputs, busy and preempt bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase_valid  <= 1'b0;
            r_phase_sel    <= 3'd0;
            r_phase_time   <= '0;
            r_phase_emerg  <= 1'b0;
            r_preempt      <= 1'b0;
            r_preempt_used <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_phase_valid  <= w_valid_nxt;
            r_phase_sel    <= w_sel_nxt;
            r_phase_time   <= w_time_nxt;
            r_phase_emerg  <= w_emerg_nxt;
            r_preempt      <= w_preempt_nxt;
            r_preempt_used <= w_preempt_used_nxt;
            r_busy         <= w_busy_nxt;
        end
    end

    // Sticky request latches (a new request beats a same-edge clear) and rr pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_veh_pend <= 4'b0000;
            r_ped_pend <= 1'b0;
            r_emg_pend <= 4'b0000;
            r_rr       <= 2'd0;
        end else begin
            r_veh_pend <= (r_veh_pend & ~w_veh_clr) | w_car;
            r_ped_pend <= (r_ped_pend & ~w_ped_clr) | pedestrian_button;
            r_emg_pend <= (r_emg_pend & ~w_emg_clr) | w_emg_in;
            r_rr       <= w_rr_nxt;
        end
    end

    assign phase_valid = r_phase_valid;
    assign phase_sel   = r_phase_sel;
    assign phase_time  = r_phase_time;
    assign phase_emerg = r_phase_emerg;
    assign preempt     = r_preempt;
    assign busy        = r_busy;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// -----------------------------------------------------------------------------
// Self-checking bench for tlc_phase_scheduler. Directed scenarios check
// fixed expectations; a randomized run is compared every cycle against a
// transaction-level reference model of pending request sets and grants.
// -----------------------------------------------------------------------------
module tb_tlc_phase_scheduler;

    localparam int TW       = 8;
    localparam int MAX_WAIT = 64;

    logic          clk;
    logic          reset;
    logic [3:0]    car;            // [0]=N [1]=S [2]=E [3]=W
    logic          ped;
    logic [3:0]    emergency;
    logic          ready;
    logic          done;
    logic          phase_valid;
    logic [2:0]    phase_sel;
    logic [TW-1:0] phase_time;
    logic          phase_emerg;
    logic          preempt;
    logic          busy;

    int n_cmp;
    int n_fail;

    tlc_phase_scheduler dut (
        .clk               (clk),
        .reset             (reset),
        .car_n             (car[0]),
        .car_s             (car[1]),
        .car_e             (car[2]),
        .car_w             (car[3]),
        .pedestrian_button (ped),
        .emergency         (emergency),
        .phase_valid       (phase_valid),
        .phase_ready       (ready),
        .phase_sel         (phase_sel),
        .phase_time        (phase_time),
        .phase_emerg       (phase_emerg),
        .phase_done        (done),
        .preempt           (preempt),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit            m_veh [4];
    bit            m_emg [4];
    bit            m_ped;
    int            m_rr;
    int            m_stage;        // 0 nothing issued, 1 offered, 2 running
    bit            m_pre_used;
    int            m_wait [4];
    logic          e_valid;
    logic [2:0]    e_sel;
    logic [TW-1:0] e_time;
    logic          e_emerg;
    logic          e_preempt;
    logic          e_busy;

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin
            m_veh[d] = 0; m_emg[d] = 0; m_wait[d] = 0;
        end
        m_ped = 0; m_rr = 0; m_stage = 0; m_pre_used = 0;
        e_valid = 0; e_sel = 0; e_time = 0; e_emerg = 0; e_preempt = 0; e_busy = 0;
    endtask

    task automatic model_pick(output bit found, output int sel, output bit emg, output int tm);
        found = 0; sel = 0; emg = 0; tm = 0;
        for (int d = 0; d < 4 && !found; d++)
            if (m_emg[d]) begin found = 1; sel = d; emg = 1; tm = 30; end
`ifdef TLC_STARVE_GUARD_EN
        for (int k = 0; k < 4 && !found; k++)
            if (m_veh[(m_rr + k) % 4] && m_wait[(m_rr + k) % 4] >= MAX_WAIT) begin
                found = 1; sel = (m_rr + k) % 4; tm = 20;
            end
`endif
        if (!found && m_ped) begin found = 1; sel = 4; tm = 15; end
        for (int k = 0; k < 4 && !found; k++)
            if (m_veh[(m_rr + k) % 4]) begin found = 1; sel = (m_rr + k) % 4; tm = 20; end
    endtask

    // Advance the model by one clock edge using the inputs the bench is driving.
    task automatic model_edge();
        bit clr_v [4];
        bit clr_e [4];
        bit old_v [4];
        bit old_e [4];
        bit clr_p, any_e, found, emg;
        int sel, tm;
        clr_p = 0; any_e = 0;
        for (int d = 0; d < 4; d++) begin
            clr_v[d] = 0; clr_e[d] = 0; old_v[d] = m_veh[d]; old_e[d] = m_emg[d];
            any_e |= m_emg[d];
        end
        e_preempt = 0;
        if (reset !== 1'b1) begin
            model_reset();
            return;
        end
        case (m_stage)
            0: begin
                model_pick(found, sel, emg, tm);
                if (found) begin
                    e_valid = 1; e_sel = 3'(sel); e_time = TW'(tm); e_emerg = emg;
                    e_busy = 1; m_stage = 1; m_pre_used = 0;
                end
            end
            1: begin
                if (ready) begin
                    e_valid = 0; m_stage = 2;
                    if (e_emerg) clr_e[e_sel[1:0]] = 1;
                    else if (e_sel == 3'd4) clr_p = 1;
                    else begin clr_v[e_sel[1:0]] = 1; m_rr = (int'(e_sel) + 1) % 4; end
                end
            end
            2: begin
                if (done) begin
                    m_stage = 0; e_sel = 0; e_time = 0; e_emerg = 0; e_busy = 0;
                end else if (!e_emerg && any_e && !m_pre_used) begin
                    e_preempt = 1; m_pre_used = 1;
                end
            end
            default: m_stage = 0;
        endcase
        for (int d = 0; d < 4; d++) begin
            if (clr_v[d]) m_wait[d] = 0;
            else if (old_v[d] && m_wait[d] < MAX_WAIT) m_wait[d]++;
            m_veh[d] = (old_v[d] && !clr_v[d]) || car[d];
            m_emg[d] = (old_e[d] && !clr_e[d]) || emergency[3 - d];
        end
        m_ped = (m_ped && !clr_p) || ped;
    endtask

    // One clock edge; afterwards we sit 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic pulse_done();
        done = 1'b1; tick(); done = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0; car = 4'b0; ped = 1'b0; emergency = 4'b0; ready = 1'b0; done = 1'b0;
        model_reset();
        tick(); tick();
        n_cmp++; if (phase_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", phase_valid); end
        n_cmp++; if (phase_sel !== 3'd0)   begin n_fail++; $display("FAIL reset_sel got %0d want 0", phase_sel); end
        n_cmp++; if (phase_time !== 8'd0)  begin n_fail++; $display("FAIL reset_time got %0d want 0", phase_time); end
        n_cmp++; if (phase_emerg !== 1'b0) begin n_fail++; $display("FAIL reset_emerg got %b want 0", phase_emerg); end
        n_cmp++; if (preempt !== 1'b0)     begin n_fail++; $display("FAIL reset_preempt got %b want 0", preempt); end
        n_cmp++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        reset = 1'b1;
    endtask

    task automatic test_single_car();
        car[0] = 1'b1; tick(); car[0] = 1'b0;
        n_cmp++; if (phase_valid !== 1'b0) begin n_fail++; $display("FAIL t1_early_valid got %b want 0", phase_valid); end
        tick();
        n_cmp++; if (phase_valid !== 1'b1) begin n_fail++; $display("FAIL t1_valid got %b want 1", phase_valid); end
        n_cmp++; if (phase_sel !== 3'd0)   begin n_fail++; $display("FAIL t1_sel got %0d want 0", phase_sel); end
        n_cmp++; if (phase_time !== 8'd20) begin n_fail++; $display("FAIL t1_time got %0d want 20", phase_time); end
        n_cmp++; if (busy !== 1'b1)        begin n_fail++; $display("FAIL t1_busy_issue got %b want 1", busy); end
        ready = 1'b1; tick(); ready = 1'b0;
        n_cmp++; if (phase_valid !== 1'b0) begin n_fail++; $display("FAIL t1_valid_drop got %b want 0", phase_valid); end
        tick(); tick(); tick();
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy_run got %b want 1", busy); end
        pulse_done();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy_done got %b want 0", busy); end
        tick(); tick();
        n_cmp++; if (phase_valid !== 1'b0) begin n_fail++; $display("FAIL t1_latch_cleared valid got %b want 0", phase_valid); end
    endtask

    task automatic test_rr_order();
        int exp_order [5] = '{1, 2, 3, 0, 3};
        car = 4'b1110; tick(); car = 4'b0000;
        ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            if (g == 3) begin car = 4'b1001; tick(); car = 4'b0000; end
            for (int k = 0; k < 10 && phase_valid !== 1'b1; k++) tick();
            n_cmp++;
            if (phase_valid !== 1'b1) begin
                n_fail++; $display("FAIL t2_timeout grant %0d valid got %b want 1", g, phase_valid);
            end else if (phase_sel !== 3'(exp_order[g])) begin
                n_fail++; $display("FAIL t2_order grant %0d sel got %0d want %0d", g, phase_sel, exp_order[g]);
            end
            for (int k = 0; k < 5; k++) tick();
            pulse_done();
        end
        ready = 1'b0;
    endtask

    task automatic test_preempt();
        car[3] = 1'b1; tick(); car[3] = 1'b0;
        tick();
        n_cmp++; if (phase_sel !== 3'd3) begin n_fail++; $display("FAIL t3_west sel got %0d want 3", phase_sel); end
        ready = 1'b1; tick(); ready = 1'b0;
        emergency = 4'b1000; tick();
        n_cmp++; if (preempt !== 1'b0) begin n_fail++; $display("FAIL t3_pre_early got %b want 0", preempt); end
        tick(); emergency = 4'b0000;
        n_cmp++; if (preempt !== 1'b1) begin n_fail++; $display("FAIL t3_pre_pulse got %b want 1", preempt); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (preempt !== 1'b0) begin n_fail++; $display("FAIL t3_pre_after%0d got %b want 0", k, preempt); end
        end
        pulse_done(); tick();
        n_cmp++; if (phase_sel !== 3'd0)   begin n_fail++; $display("FAIL t3_emg_sel got %0d want 0", phase_sel); end
        n_cmp++; if (phase_emerg !== 1'b1) begin n_fail++; $display("FAIL t3_emg_flag got %b want 1", phase_emerg); end
        n_cmp++; if (phase_time !== 8'd30) begin n_fail++; $display("FAIL t3_emg_time got %0d want 30", phase_time); end
        ready = 1'b1; tick(); ready = 1'b0;
        emergency = 4'b0001; tick(); emergency = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if (preempt !== 1'b0) begin n_fail++; $display("FAIL t3_no_pre_emg%0d got %b want 0", k, preempt); end
        end
        pulse_done(); tick();
        n_cmp++; if (phase_sel !== 3'd3 || phase_emerg !== 1'b1) begin
            n_fail++; $display("FAIL t3_queued_emg sel/emerg got %0d/%b want 3/1", phase_sel, phase_emerg);
        end
        ready = 1'b1; tick(); ready = 1'b0;
        pulse_done();
    endtask

    task automatic test_ped_hold();
        ped = 1'b1; car[2] = 1'b1; tick(); ped = 1'b0; car[2] = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (phase_valid !== 1'b1 || phase_sel !== 3'd4 || phase_time !== 8'd15) begin
                n_fail++;
                $display("FAIL t4_hold%0d valid/sel/time got %b/%0d/%0d want 1/4/15", k, phase_valid, phase_sel, phase_time);
            end
            if (k == 4) pulse_done();
            else tick();
        end
        ready = 1'b1; tick(); ready = 1'b0;
        n_cmp++; if (phase_valid !== 1'b0) begin n_fail++; $display("FAIL t4_accept valid got %b want 0", phase_valid); end
        pulse_done(); tick();
        n_cmp++; if (phase_sel !== 3'd2 || phase_time !== 8'd20) begin
            n_fail++; $display("FAIL t4_east sel/time got %0d/%0d want 2/20", phase_sel, phase_time);
        end
        ready = 1'b1; tick(); ready = 1'b0;
        pulse_done();
    endtask

    task automatic test_mid_reset();
        car[0] = 1'b1; tick(); car[0] = 1'b0;
        ready = 1'b1; tick(); tick(); ready = 1'b0;
        car[1] = 1'b1; tick(); car[1] = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t5_running busy got %b want 1", busy); end
        reset = 1'b0; model_reset(); #1;
        n_cmp++; if ({phase_valid, phase_sel, phase_time, phase_emerg, preempt, busy} !== 15'd0) begin
            n_fail++; $display("FAIL t5_async_reset outputs got %b want 0", {phase_valid, phase_sel, phase_time, phase_emerg, preempt, busy});
        end
        tick(); tick(); reset = 1'b1;
        tick(); tick();
        n_cmp++; if (phase_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL t5_latches_cleared valid/busy got %b/%b want 0/0", phase_valid, busy);
        end
        car = 4'b0101; tick(); car = 4'b0000;
        n_cmp++; if (phase_valid !== 1'b0) begin n_fail++; $display("FAIL t5_latency valid got %b want 0", phase_valid); end
        tick();
        n_cmp++; if (phase_valid !== 1'b1 || phase_sel !== 3'd0 || phase_time !== 8'd20) begin
            n_fail++; $display("FAIL t5_rr_reset valid/sel/time got %b/%0d/%0d want 1/0/20", phase_valid, phase_sel, phase_time);
        end
        ready = 1'b1; tick(); ready = 1'b0; pulse_done(); tick();
        n_cmp++; if (phase_sel !== 3'd2) begin n_fail++; $display("FAIL t5_east_next sel got %0d want 2", phase_sel); end
        ready = 1'b1; tick(); ready = 1'b0; pulse_done();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 4; d++) begin
                car[d]       = ($urandom % 16) == 0;
                emergency[d] = ($urandom % 80) == 0;
            end
            ped   = ($urandom % 24) == 0;
            ready = ($urandom % 3) != 0;
            done  = ($urandom % 6) == 0;
            tick();
            n_cmp++; if (phase_valid !== e_valid) begin n_fail++; $display("FAIL rnd_valid cyc %0d got %b want %b", c, phase_valid, e_valid); end
            n_cmp++; if (phase_sel !== e_sel)     begin n_fail++; $display("FAIL rnd_sel cyc %0d got %0d want %0d", c, phase_sel, e_sel); end
            n_cmp++; if (phase_time !== e_time)   begin n_fail++; $display("FAIL rnd_time cyc %0d got %0d want %0d", c, phase_time, e_time); end
            n_cmp++; if (phase_emerg !== e_emerg) begin n_fail++; $display("FAIL rnd_emerg cyc %0d got %b want %b", c, phase_emerg, e_emerg); end
            n_cmp++; if (preempt !== e_preempt)   begin n_fail++; $display("FAIL rnd_preempt cyc %0d got %b want %b", c, preempt, e_preempt); end
            n_cmp++; if (busy !== e_busy)         begin n_fail++; $display("FAIL rnd_busy cyc %0d got %b want %b", c, busy, e_busy); end
        end
        car = 4'b0; ped = 1'b0; emergency = 4'b0; ready = 1'b1; done = 1'b1;
        for (int k = 0; k < 100; k++) tick();
        ready = 1'b0; done = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0 || phase_valid !== 1'b0) begin
            n_fail++; $display("FAIL rnd_drain busy/valid got %b/%b want 0/0", busy, phase_valid);
        end
    endtask

`ifdef TLC_STARVE_GUARD_EN
    task automatic test_starve();
        int  age;
        bit  w_seen;
        ready = 1'b1; ped = 1'b1; car[3] = 1'b1; tick(); car[3] = 1'b0;
        age = 0; w_seen = 0;
        for (int k = 0; k < 400 && !w_seen; k++) begin
            done = (busy === 1'b1 && phase_valid === 1'b0);
            tick(); age++;
            if (phase_valid === 1'b1 && phase_sel === 3'd3) begin
                w_seen = 1;
                n_cmp++; if (age < MAX_WAIT + 1) begin n_fail++; $display("FAIL starve_early W issued at age %0d want >= %0d", age, MAX_WAIT + 1); end
            end else if (phase_valid === 1'b1 && phase_sel === 3'd4 && age >= MAX_WAIT + 1) begin
                n_cmp++; n_fail++; $display("FAIL starve_ped_first PED issued at age %0d want W", age);
            end
        end
        n_cmp++; if (!w_seen) begin n_fail++; $display("FAIL starve_timeout W issued got 0 want 1"); end
        ped = 1'b0; done = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        done = 1'b0; ready = 1'b0;
    endtask
`endif

    initial begin
        n_cmp = 0; n_fail = 0;
        test_reset();
        test_single_car();
        test_rr_order();
        test_preempt();
        test_ped_hold();
        test_mid_reset();
        test_random();
`ifdef TLC_STARVE_GUARD_EN
        test_starve();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
